// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial add/sub sequencer driving one external 4-bit CLA slice

// cla4_slice - 4-bit carry-lookahead adder slice, the unit the sequencer time-shares
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms with every carry expanded directly from cin (no ripple)
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// nibble_serial_add_ctrl - WIDTH-bit add/sub done one nibble per clock, LSB first
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_res,
  input  logic             add_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Captured operands; b_q already holds ~b for subtraction so the slice always adds
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] res_q;

  logic [WIDTH-1:0] out_res_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  logic             accept;
  logic             last_nib;
  logic             result_taken;
  logic [WIDTH-1:0] full_res;
  logic             ovf_next;

  assign in_ready     = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept       = in_valid & in_ready;
  assign last_nib     = (state_q == RUN) && (idx_q == LAST_IDX);
  assign result_taken = (state_q == DONE) & out_ready;

  // On the final nibble the lower nibbles are already in res_q; the top one comes from the slice
  assign full_res = {add_res, res_q[WIDTH-5:0]};
  assign ovf_next = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (full_res[WIDTH-1] ^ a_q[WIDTH-1]);

  assign out_valid = (state_q == DONE);
  assign out_res   = out_res_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, count nibbles in RUN, hold in DONE until the sink takes the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice drive: current nibble pair, first carry-in is the subtract +1; quiet outside RUN
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[4*idx_q +: 4];
      add_b   = b_q[4*idx_q +: 4];
      add_cin = (idx_q == '0) ? sub_q : carry_q;
    end
  end

  // Operand capture and per-nibble accumulation of the slice result and carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b ^ {WIDTH{in_sub}};
        sub_q   <= in_sub;
        carry_q <= 1'b0;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        res_q[4*idx_q +: 4] <= add_res;
        carry_q             <= add_cout;
        idx_q               <= last_nib ? '0 : idx_q + IW'(1);
      end
    end
  end

  // Result and flag registers: loaded on the last nibble, held through DONE, cleared on handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end else if (last_nib) begin
      out_res_q  <= full_res;
      out_cout_q <= add_cout;
      out_ovf_q  <= ovf_next;
      out_zero_q <= ~|full_res;
    end else if (result_taken) begin
      out_res_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for nibble_serial_add_ctrl with WIDTH=8

module tb_nibble_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_res;
  logic         add_cout;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_res(add_res), .add_cout(add_cout)
  );

  cla4_slice u_slice (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_res), .cout(add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, u, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    u  = sub ? ua - ub : ua + ub;
    s  = sub ? sa - sb : sa + sb;
    u  = (u + 256) % 256;
    e.res  = W'(u);
    e.cout = sub ? (ua >= ub) : ((ua + ub) > 255);
    e.ovf  = (s < -128) || (s > 127);
    e.zero = (u == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: while a result is presented, it must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", out_res);
      end else begin
        chk("res",       32'(out_res),  32'(q[0].res));
        chk("cout",      32'(out_cout), 32'(q[0].cout));
        chk("ovf",       32'(out_ovf),  32'(q[0].ovf));
        chk("zero",      32'(out_zero), 32'(q[0].zero));
        chk("done_add_idle", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'(out_ready));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Present one operand set (entered just after a rising edge); returns cycles waited for acceptance
  task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_sub   = sub;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
      @(negedge clk);
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (in_ready) q.push_back(model(sub, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sub   = 1'($urandom);
    in_a     = W'($urandom);
    in_b     = W'($urandom);
  endtask

  // Count edges from acceptance until out_valid; returns at the negedge where it is seen
  task automatic wait_valid(output int e);
    e = 0;
    @(negedge clk);
    while (!out_valid && e < 50) begin
      @(posedge clk); #1;
      e++;
      @(negedge clk);
    end
  endtask

  logic       d_sub [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] d_a   [5] = '{8'h3C, 8'h05, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] d_b   [5] = '{8'h0F, 8'h05, 8'h01, 8'h01, 8'h01};
  logic [7:0] d_res [5] = '{8'h4B, 8'h00, 8'h80, 8'h00, 8'hFF};
  logic [2:0] d_flg [5] = '{3'b000, 3'b101, 3'b010, 3'b101, 3'b000};

  initial begin
    int w, lat, acc, cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out",       32'({out_res, out_cout, out_ovf, out_zero}), 32'd0);
    chk("rst_add",       32'({add_a, add_b, add_cin}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with constant expectations and latency
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(d_sub[i], d_a[i], d_b[i], w);
      wait_valid(lat);
      chk("dir_latency", 32'(lat), 32'd2);
      chk("dir_res",     32'(out_res), 32'(d_res[i]));
      chk("dir_flags",   32'({out_cout, out_ovf, out_zero}), 32'(d_flg[i]));
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_clear", 32'({out_res, out_cout, out_ovf, out_zero}), 32'd0);
      @(posedge clk); #1;
    end

    // Backpressure: result held, in_ready low, in_valid pulses ignored
    out_ready = 1'b0;
    send(1'b0, 8'hA5, 8'h5A, w);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back: new op accepted in the same cycle the previous result is taken
    out_ready = 1'b0;
    send(1'b1, 8'h10, 8'h20, w);
    wait_valid(lat);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b0, 8'h81, 8'h82, w);
    chk("b2b_accept_wait", 32'(w), 32'd0);
    wait_valid(lat);
    chk("b2b_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Reset mid-RUN drops the operation
    send(1'b0, 8'h11, 8'h22, w);
    chk("run_add_a", 32'(add_a), 32'h1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_add",   32'({add_a, add_b, add_cin}), 32'd0);
    chk("mid_rst_out",   32'({out_res, out_cout, out_ovf, out_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(1'b1, 8'h80, 8'h01, w);
    wait_valid(lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Random traffic; operands keep changing while the DUT is busy
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 70000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sub    = 1'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(in_sub, in_a, in_b));
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_ops_done", 32'(acc), 32'd10000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
